// File: rtl/fll_ctrl_pkg.sv
// Shared types and constants for the FLL configuration-port controller.
package fll_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR1,
        ST_GAP,
        ST_WR2,
        ST_WAIT_LOCK,
        ST_DONE,
        ST_TMO,
        ST_SW_XFER,
        ST_SW_REL
    } fll_state_e;

    localparam logic [1:0] FLL_ADDR_STATUS = 2'd0;
    localparam logic [1:0] FLL_ADDR_CFG1   = 2'd1;
    localparam logic [1:0] FLL_ADDR_CFG2   = 2'd2;
    localparam logic [1:0] FLL_ADDR_INTEG  = 2'd3;

    localparam logic FLL_WRITE = 1'b0;
    localparam logic FLL_READ  = 1'b1;

    // States in which a start pulse or a software request may be taken.
    function automatic logic is_rest_state(input fll_state_e s);
        return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_TMO);
    endfunction

endpackage

// File: rtl/fll_cfg_ctrl_if.sv
// Request/acknowledge register-access bus, used for both the software side
// and the FLL side of the controller.
interface fll_cfg_ctrl_if;
    logic        req;
    logic        wrn;
    logic [1:0]  add;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, wrn, add, wdata, input  ack, rdata);
    modport slave  (input  req, wrn, add, wdata, output ack, rdata);
endinterface

// File: rtl/fll_lock_sync.sv
// Two-flop synchronizer for the FLL lock indication.
module fll_lock_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/fll_cfg_ctrl.sv
// FLL configuration-port sequencer: boot writes, lock wait with timeout, and
// one-at-a-time forwarding of software FLL register accesses.
//
// state        | meaning
// IDLE         | after reset, nothing started
// WR1          | boot write of CFG1_INIT to address 1
// GAP          | one idle cycle between the boot writes
// WR2          | boot write of CFG2_INIT to address 2
// WAIT_LOCK    | waiting for synchronized lock, bounded by LOCK_TIMEOUT
// DONE         | lock reached
// TMO          | lock wait expired
// SW_XFER      | software transaction outstanding on the FLL port
// SW_REL       | waiting for the software requester to drop its request
module fll_cfg_ctrl
    import fll_ctrl_pkg::*;
#(
    parameter logic [31:0] CFG1_INIT        = 32'h0000_0000,
    parameter logic [31:0] CFG2_INIT        = 32'h0000_0000,
    parameter int unsigned LOCK_TIMEOUT     = 1024,
    parameter bit          FETCH_ON_TIMEOUT = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic           fetch_enable_i,
    output logic           fetch_enable_o,
    output logic           done_o,
    output logic           timeout_o,
    output logic           lock_lost_o,
    fll_cfg_ctrl_if.slave  sw,
    fll_cfg_ctrl_if.master fll,
    input  logic           fll_lock_i
);

    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(LOCK_TIMEOUT);

    fll_state_e       state_q;
    fll_state_e       ret_q;
    logic             pend_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             done_q;
    logic             tmo_q;
    logic             lost_q;
    logic             fetch_q;
    logic             fll_req_q;
    logic             fll_wrn_q;
    logic [1:0]       fll_add_q;
    logic [31:0]      fll_wdata_q;
    logic             sw_ack_q;
    logic [31:0]      sw_rdata_q;

    logic lock_s;
    logic go_boot;
    logic go_sw;

    fll_lock_sync u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d_i (fll_lock_i),
        .q_o (lock_s)
    );

    // A start seen during a software transaction is deferred until the
    // requester releases, and then beats any new software request.
    always_comb begin
        cnt_d   = cnt_q + CNT_W'(1);
        go_boot = (is_rest_state(state_q) && start_i) ||
                  ((state_q == ST_SW_REL) && !sw.req && (pend_q || start_i));
        go_sw   = is_rest_state(state_q) && !start_i && sw.req;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ret_q       <= ST_IDLE;
            pend_q      <= 1'b0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            tmo_q       <= 1'b0;
            lost_q      <= 1'b0;
            fetch_q     <= 1'b0;
            fll_req_q   <= 1'b0;
            fll_wrn_q   <= FLL_READ;
            fll_add_q   <= FLL_ADDR_STATUS;
            fll_wdata_q <= '0;
            sw_ack_q    <= 1'b0;
            sw_rdata_q  <= '0;
        end else begin
            fetch_q <= fetch_enable_i & (done_q | (tmo_q & FETCH_ON_TIMEOUT));

            if ((state_q == ST_DONE) && !lock_s) begin
                lost_q <= 1'b1;
            end

            if (go_boot) begin
                state_q     <= ST_WR1;
                pend_q      <= 1'b0;
                done_q      <= 1'b0;
                tmo_q       <= 1'b0;
                lost_q      <= 1'b0;
                sw_ack_q    <= 1'b0;
                fll_req_q   <= 1'b1;
                fll_wrn_q   <= FLL_WRITE;
                fll_add_q   <= FLL_ADDR_CFG1;
                fll_wdata_q <= CFG1_INIT;
            end else if (go_sw) begin
                state_q     <= ST_SW_XFER;
                ret_q       <= state_q;
                fll_req_q   <= 1'b1;
                fll_wrn_q   <= sw.wrn;
                fll_add_q   <= sw.add;
                fll_wdata_q <= sw.wdata;
            end else begin
                case (state_q)
                    ST_WR1: begin
                        if (fll.ack) begin
                            fll_req_q <= 1'b0;
                            state_q   <= ST_GAP;
                        end
                    end
                    ST_GAP: begin
                        fll_req_q   <= 1'b1;
                        fll_wrn_q   <= FLL_WRITE;
                        fll_add_q   <= FLL_ADDR_CFG2;
                        fll_wdata_q <= CFG2_INIT;
                        state_q     <= ST_WR2;
                    end
                    ST_WR2: begin
                        if (fll.ack) begin
                            fll_req_q <= 1'b0;
                            cnt_q     <= '0;
                            state_q   <= ST_WAIT_LOCK;
                        end
                    end
                    ST_WAIT_LOCK: begin
                        // Lock is checked first so it wins a tie with the timeout.
                        if (lock_s) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else if (cnt_d == CNT_LIMIT) begin
                            tmo_q   <= 1'b1;
                            state_q <= ST_TMO;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    ST_SW_XFER: begin
                        if (start_i) begin
                            pend_q <= 1'b1;
                        end
                        if (fll.ack) begin
                            fll_req_q  <= 1'b0;
                            sw_ack_q   <= 1'b1;
                            sw_rdata_q <= fll.rdata;
                            state_q    <= ST_SW_REL;
                        end
                    end
                    ST_SW_REL: begin
                        if (start_i) begin
                            pend_q <= 1'b1;
                        end
                        if (!sw.req) begin
                            sw_ack_q <= 1'b0;
                            state_q  <= ret_q;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign fetch_enable_o = fetch_q;
    assign done_o         = done_q;
    assign timeout_o      = tmo_q;
    assign lock_lost_o    = lost_q;
    assign fll.req        = fll_req_q;
    assign fll.wrn        = fll_wrn_q;
    assign fll.add        = fll_add_q;
    assign fll.wdata      = fll_wdata_q;
    assign sw.ack         = sw_ack_q;
    assign sw.rdata       = sw_rdata_q;

endmodule
